// File: rtl/div_pkg.sv
// Shared types and constants for the sequential reciprocal divide path.
package div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NORM,
    ST_LOOK,
    ST_INTERP,
    ST_DENORM,
    ST_DONE
  } div_state_e;

  localparam logic [31:0] DIV_SAT = 32'h7FFF_FFFF;

  localparam int DIV_PNT_W  = 16;
  localparam int DIV_SLP_W  = 8;
  localparam int DIV_FRAC_W = 4;
  localparam int DIV_IDX_W  = 5;

endpackage

// File: rtl/div_lzc32.sv
// Combinational 32-bit leading-zero counter with an all-zero flag.
module div_lzc32 (
  input  logic [31:0] i_data,
  output logic [4:0]  o_cnt,
  output logic        o_zero
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    o_cnt  = '0;
    o_zero = (i_data == 32'd0);
    for (int i = 0; i < 32; i++) begin
      if (i_data[i]) o_cnt = 5'(31 - i);
    end
  end

endmodule

// File: rtl/div_rcp_seq.sv
// Reciprocal controller: normalize, table lookup, interpolate, denormalize,
// then hold the signed result until the consumer takes it.
module div_rcp_seq
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  output logic [DIV_IDX_W-1:0]  tbl_idx,
  input  logic [DIV_PNT_W-1:0]  tbl_pnt,
  input  logic [DIV_SLP_W-1:0]  tbl_slp,
  output logic [DIV_PNT_W-1:0]  interp_pnt,
  output logic [DIV_SLP_W-1:0]  interp_slp,
  output logic [DIV_FRAC_W-1:0] interp_frac,
  input  logic [DIV_PNT_W-1:0]  interp_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data
);

  div_state_e             r_state;
  logic                   r_sign;
  logic                   r_zero;
  logic [31:0]            r_mag;
  logic [4:0]             r_lz;
  logic [DIV_FRAC_W-1:0]  r_normFrac;
  logic [DIV_IDX_W-1:0]   r_tblIdx;
  logic [DIV_PNT_W-1:0]   r_pnt;
  logic [DIV_SLP_W-1:0]   r_slp;
  logic [DIV_FRAC_W-1:0]  r_frac;
  logic [DIV_PNT_W-1:0]   r_sum;
  logic                   r_inReady;
  logic                   r_outValid;
  logic [31:0]            r_outData;

  logic [31:0] w_inMag;
  logic [4:0]  w_lz;
  logic        w_lzZero;
  logic [8:0]  w_normHi;
  logic [4:0]  w_shift;
  logic [31:0] w_r;
  logic [31:0] w_res;

  div_lzc32 u_lzc (
    .i_data (r_mag),
    .o_cnt  (w_lz),
    .o_zero (w_lzZero)
  );

  // Magnitude as unsigned, so the most negative operand maps to 0x8000_0000.
  assign w_inMag  = in_data[31] ? (32'd0 - in_data) : in_data;
  // Only norm[30:22] feeds the table index and the interpolation fraction.
  assign w_normHi = 9'((r_mag << w_lz) >> 22);
  assign w_shift  = 5'd31 - r_lz;
  assign w_r      = {2'b01, r_sum, 14'b0} >> w_shift;
  assign w_res    = r_zero ? DIV_SAT : (r_sign ? ~w_r : w_r);

  assign in_ready    = r_inReady;
  assign out_valid   = r_outValid;
  assign out_data    = r_outData;
  assign tbl_idx     = r_tblIdx;
  assign interp_pnt  = r_pnt;
  assign interp_slp  = r_slp;
  assign interp_frac = r_frac;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state    <= ST_IDLE;
      r_sign     <= 1'b0;
      r_zero     <= 1'b0;
      r_mag      <= '0;
      r_lz       <= '0;
      r_normFrac <= '0;
      r_tblIdx   <= '0;
      r_pnt      <= '0;
      r_slp      <= '0;
      r_frac     <= '0;
      r_sum      <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_outData  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sign    <= in_data[31];
            r_mag     <= w_inMag;
            r_zero    <= (w_inMag == 32'd0);
            r_inReady <= 1'b0;
            r_state   <= ST_NORM;
          end
        end
        ST_NORM: begin
          r_lz       <= w_lzZero ? 5'd0 : w_lz;
          r_normFrac <= w_normHi[3:0];
          r_tblIdx   <= w_normHi[8:4];
          r_state    <= ST_LOOK;
        end
        ST_LOOK: begin
          r_pnt   <= tbl_pnt;
          r_slp   <= tbl_slp;
          r_frac  <= r_normFrac;
          r_state <= ST_INTERP;
        end
        ST_INTERP: begin
          r_sum   <= interp_sum;
          r_state <= ST_DENORM;
        end
        ST_DENORM: begin
          r_outData  <= w_res;
          r_outValid <= 1'b1;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_rcp_seq.sv
// Self-checking bench for div_rcp_seq with behavioural table/interpolator
// models and an arithmetic reference for the reciprocal result.
module tb_div_rcp_seq;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic [4:0]  tbl_idx;
  logic [15:0] tbl_pnt;
  logic [7:0]  tbl_slp;
  logic [15:0] interp_pnt;
  logic [7:0]  interp_slp;
  logic [3:0]  interp_frac;
  logic [15:0] interp_sum;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  int errors = 0;
  int checks = 0;

  logic        useForce = 1'b1;
  logic [15:0] forcedSum = 16'd0;
  logic [31:0] expQ[$];
  logic [31:0] lastOut;
  logic [4:0]  lastIdx;
  logic [3:0]  lastFrac;

  always #5 clk = ~clk;

  div_rcp_seq dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .tbl_idx     (tbl_idx),
    .tbl_pnt     (tbl_pnt),
    .tbl_slp     (tbl_slp),
    .interp_pnt  (interp_pnt),
    .interp_slp  (interp_slp),
    .interp_frac (interp_frac),
    .interp_sum  (interp_sum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

  function automatic logic [15:0] tablePnt(input logic [4:0] idx);
    return 16'h4000 + 16'(idx) * 16'h0311;
  endfunction

  function automatic logic [7:0] tableSlp(input logic [4:0] idx);
    return 8'h80 ^ {idx, 3'b101};
  endfunction

  assign tbl_pnt    = useForce ? 16'd0 : tablePnt(tbl_idx);
  assign tbl_slp    = useForce ? 8'd0  : tableSlp(tbl_idx);
  assign interp_sum = useForce ? forcedSum : 16'(interp_pnt + interp_slp * interp_frac);

  // Reference: reciprocal = (1 + sum/2^16) scaled by 2^(lz-1), then re-signed.
  function automatic logic [31:0] expectRcp(input logic [31:0] d, input logic forceIt,
                                            input logic [15:0] fsum);
    logic [31:0] mag;
    logic [31:0] m;
    logic [15:0] sum;
    logic [31:0] r;
    int n;
    mag = d[31] ? (32'd0 - d) : d;
    if (mag == 32'd0) return 32'h7FFF_FFFF;
    m = mag;
    n = 0;
    while (m < 32'h8000_0000) begin
      m = m * 2;
      n++;
    end
    if (forceIt) sum = fsum;
    else sum = 16'(tablePnt(m[30:26]) + tableSlp(m[30:26]) * m[25:22]);
    r = 32'((64'h4000_0000 + 64'(sum) * 64'h4000) / (64'h1 << (31 - n)));
    return d[31] ? ~r : r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Every cycle a result is held it must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset_l && out_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL out_data_unexpected: got 0x%08h with no result pending", out_data);
      end else begin
        checkOutput("out_data_model", out_data, expQ[0]);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] d, input int hold);
    int waitN;
    waitN = 0;
    while (!in_ready && waitN < 20) begin
      @(negedge clk);
      waitN++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    expQ.push_back(expectRcp(d, useForce, forcedSum));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    for (int n = 0; n < 4; n++) begin
      checkOutput("busy_out_valid", 32'(out_valid), 32'd0);
      checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
      if (n == 1) lastIdx = tbl_idx;
      if (n == 2) lastFrac = interp_frac;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checkOutput("latency_out_valid", 32'(out_valid), 32'd1);
    lastOut = out_data;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_out_data", out_data, lastOut);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    if (expQ.size() != 0) void'(expQ.pop_front());
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("post_handoff_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_handoff_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_out_data"}, out_data, 32'd0);
    checkOutput({tag, "_tbl_idx"}, 32'(tbl_idx), 32'd0);
    checkOutput({tag, "_interp_pnt"}, 32'(interp_pnt), 32'd0);
    checkOutput({tag, "_interp_slp"}, 32'(interp_slp), 32'd0);
    checkOutput({tag, "_interp_frac"}, 32'(interp_frac), 32'd0);
  endtask

  task automatic resetDuringInterp();
    useForce = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h0000_0300;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_l = 1'b0;
    #1 checkResetValues("async_reset");
    expQ.delete();
    @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
    checkOutput("after_release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    reset_l = 1'b1;
    @(negedge clk);

    useForce = 1'b1;
    forcedSum = 16'h0000;
    applyStimulus(32'h0000_0001, 0);
    checkOutput("rcp_pos_one", lastOut, 32'h4000_0000);
    applyStimulus(32'hFFFF_FFFF, 0);
    checkOutput("rcp_neg_one", lastOut, 32'hBFFF_FFFF);
    applyStimulus(32'h0000_0000, 0);
    checkOutput("rcp_zero_forced", lastOut, 32'h7FFF_FFFF);
    useForce = 1'b0;
    applyStimulus(32'h0000_0000, 0);
    checkOutput("rcp_zero_table", lastOut, 32'h7FFF_FFFF);

    useForce = 1'b1;
    forcedSum = 16'h1234;
    applyStimulus(32'h0000_0300, 0);
    checkOutput("rcp_300_idx", 32'(lastIdx), 32'h10);
    checkOutput("rcp_300_frac", 32'(lastFrac), 32'h0);
    checkOutput("rcp_300_out", lastOut, 32'h0022_4680);

    forcedSum = 16'h0000;
    applyStimulus(32'h0000_0001, 10);
    checkOutput("rcp_hold_out", lastOut, 32'h4000_0000);

    resetDuringInterp();
    useForce = 1'b1;
    forcedSum = 16'h0000;
    applyStimulus(32'h0000_0001, 0);
    checkOutput("rcp_after_reset", lastOut, 32'h4000_0000);

    useForce = 1'b0;
    applyStimulus(32'h8000_0000, 1);
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 7))
        0: d = 32'h8000_0000;
        1: d = 32'h0000_0000;
        2: d = $urandom >> $urandom_range(0, 31);
        3: d = 32'd0 - ($urandom >> $urandom_range(0, 31));
        default: d = $urandom;
      endcase
      applyStimulus(d, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
